// File: rtl/boot_loader_ctrl.sv
// Boot loader controller: holds the CPU datapath in reset while a program
// streams into instruction memory, then releases it to run from BASE_ADDR.
// Optional build macro BOOT_CHECKSUM_EN: the s_last word is a modulo-2^32
// checksum of the program words; it is not written to memory and is
// verified in a one-cycle CHECK state before release.
//
// state   | meaning
// IDLE    | after reset, waiting for start_load
// LOAD    | accepting stream words, writing them to imem
// CHECK   | comparing running sum with received checksum (checksum build only)
// RELEASE | one cycle letting the final write land
// RUN     | datapath out of reset
// ERR     | overflow or checksum mismatch, datapath held in reset
module boot_loader_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_load,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst_n,
  output logic [31:0] boot_pc,
  output logic        busy,
  output logic        err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
`ifdef BOOT_CHECKSUM_EN
    ST_ERR     = 3'd4,
    ST_CHECK   = 3'd5
`else
    ST_ERR     = 3'd4
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          accept;
  logic          prog_word;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]   sum_q, sum_d;
  logic [31:0]   chk_q, chk_d;
`endif

  assign accept = (state_q == ST_LOAD) && s_valid;
`ifdef BOOT_CHECKSUM_EN
  assign prog_word = accept && !s_last;
`else
  assign prog_word = accept;
`endif

  // Next-state, write-port and counter logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d   = sum_q;
    chk_d   = chk_q;
`endif
    if (prog_word) begin
      we_d    = 1'b1;
      addr_d  = BASE_ADDR + (32'(count_q) << 2);
      wdata_d = s_data;
      count_d = count_q + CW'(1);
`ifdef BOOT_CHECKSUM_EN
      sum_d   = sum_q + s_data;
`endif
    end
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start_load) begin
          state_d = ST_LOAD;
          count_d = '0;
`ifdef BOOT_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (s_last) begin
`ifdef BOOT_CHECKSUM_EN
            state_d = ST_CHECK;
            chk_d   = s_data;
`else
            state_d = ST_RELEASE;
`endif
          end else if (count_q == LAST_IDX) begin
            state_d = ST_ERR;
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CHECK:   state_d = (sum_q == chk_q) ? ST_RELEASE : ST_ERR;
`endif
      ST_RELEASE: state_d = ST_RUN;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and write-port registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
`ifdef BOOT_CHECKSUM_EN
      sum_q   <= '0;
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q   <= sum_d;
      chk_q   <= chk_d;
`endif
    end
  end

  assign s_ready    = (state_q == ST_LOAD);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst_n  = (state_q == ST_RUN);
  assign boot_pc    = BASE_ADDR;
  assign err        = (state_q == ST_ERR);
`ifdef BOOT_CHECKSUM_EN
  assign busy = (state_q == ST_LOAD) || (state_q == ST_CHECK) || (state_q == ST_RELEASE);
`else
  assign busy = (state_q == ST_LOAD) || (state_q == ST_RELEASE);
`endif

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Bench for boot_loader_ctrl: two instances (default DEPTH and DEPTH=4)
// share one stimulus stream and are compared every cycle against an
// event-level model, with directed literal checks on the write sequences.
module tb_boot_loader_ctrl;
  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam logic [31:0] B1 = 32'h0000_0100;
  localparam int D0 = 256;
  localparam int D1 = 4;
`ifdef BOOT_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_load, s_valid, s_last;
  logic [31:0] s_data;
  logic [1:0]  s_ready_w, imem_we_w, cpu_rst_n_w, busy_w, err_w;
  logic [31:0] addr_w0, addr_w1, wdata_w0, wdata_w1, pc_w0, pc_w1;

  boot_loader_ctrl #(.BASE_ADDR(B0), .DEPTH(D0)) u_dut (
    .clk(clk), .rst(rst), .start_load(start_load), .s_valid(s_valid),
    .s_data(s_data), .s_last(s_last), .s_ready(s_ready_w[0]),
    .imem_we(imem_we_w[0]), .imem_addr(addr_w0), .imem_wdata(wdata_w0),
    .cpu_rst_n(cpu_rst_n_w[0]), .boot_pc(pc_w0), .busy(busy_w[0]), .err(err_w[0]));

  boot_loader_ctrl #(.BASE_ADDR(B1), .DEPTH(D1)) u_dut4 (
    .clk(clk), .rst(rst), .start_load(start_load), .s_valid(s_valid),
    .s_data(s_data), .s_last(s_last), .s_ready(s_ready_w[1]),
    .imem_we(imem_we_w[1]), .imem_addr(addr_w1), .imem_wdata(wdata_w1),
    .cpu_rst_n(cpu_rst_n_w[1]), .boot_pc(pc_w1), .busy(busy_w[1]), .err(err_w[1]));

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid = 1'b0;
  bit          m_load[2], m_rel[2], m_run[2], m_err[2], m_chkp[2], m_we[2];
  int unsigned m_cnt[2];
  logic [31:0] m_addr[2], m_data[2], m_sum[2], m_ck[2];

  function automatic int unsigned dep(input int i);
    return (i == 0) ? D0 : D1;
  endfunction
  function automatic logic [31:0] base(input int i);
    return (i == 0) ? B0 : B1;
  endfunction

  task model_edge(input int i);
    bit prog;
    if (!rst) begin
      m_load[i] = 0; m_rel[i] = 0; m_run[i] = 0; m_err[i] = 0; m_chkp[i] = 0;
      m_we[i] = 0; m_cnt[i] = 0; m_sum[i] = 0; m_ck[i] = 0;
      m_addr[i] = base(i); m_data[i] = 0;
    end else begin
      m_we[i] = 0;
      if (m_load[i]) begin
        if (s_valid) begin
          prog = CK ? !s_last : 1'b1;
          if (prog) begin
            m_we[i] = 1;
            m_addr[i] = base(i) + 32'(4 * m_cnt[i]);
            m_data[i] = s_data;
            m_sum[i] = m_sum[i] + s_data;
            m_cnt[i]++;
          end
          if (s_last) begin
            m_load[i] = 0;
            if (CK) begin m_chkp[i] = 1; m_ck[i] = s_data; end
            else m_rel[i] = 1;
          end else if (m_cnt[i] == dep(i)) begin
            m_load[i] = 0; m_err[i] = 1;
          end
        end
      end else if (m_chkp[i]) begin
        m_chkp[i] = 0;
        if (m_sum[i] == m_ck[i]) m_rel[i] = 1; else m_err[i] = 1;
      end else if (m_rel[i]) begin
        m_rel[i] = 0; m_run[i] = 1;
      end else if (start_load) begin
        m_load[i] = 1; m_run[i] = 0; m_err[i] = 0; m_cnt[i] = 0; m_sum[i] = 0;
      end
    end
  endtask

  int cyc = 0;
  // Advance the model on every active edge.
  always @(posedge clk) begin
    cyc++;
    if (!rst) m_valid = 1'b1;
    for (int i = 0; i < 2; i++) model_edge(i);
  end

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    chk("boot_pc[0]", pc_w0, B0);
    chk("boot_pc[1]", pc_w1, B1);
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("s_ready[%0d]", i), 32'(s_ready_w[i]), 32'(m_load[i]));
        chk($sformatf("imem_we[%0d]", i), 32'(imem_we_w[i]), 32'(m_we[i]));
        chk($sformatf("imem_addr[%0d]", i), (i == 0) ? addr_w0 : addr_w1, m_addr[i]);
        chk($sformatf("imem_wdata[%0d]", i), (i == 0) ? wdata_w0 : wdata_w1, m_data[i]);
        chk($sformatf("cpu_rst_n[%0d]", i), 32'(cpu_rst_n_w[i]), 32'(m_run[i]));
        chk($sformatf("busy[%0d]", i), 32'(busy_w[i]), 32'(m_load[i] | m_rel[i] | m_chkp[i]));
        chk($sformatf("err[%0d]", i), 32'(err_w[i]), 32'(m_err[i]));
      end
    end
  end

  // Write logs for directed literal checks.
  logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];
  int          wc0[$];
  always @(negedge clk) begin
    if (imem_we_w[0] === 1'b1) begin wa0.push_back(addr_w0); wd0.push_back(wdata_w0); wc0.push_back(cyc); end
    if (imem_we_w[1] === 1'b1) begin wa1.push_back(addr_w1); wd1.push_back(wdata_w1); end
  end

  task automatic clear_logs();
    wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete(); wc0.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_load = 1'b1;
    step();
    start_load = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input bit last);
    s_valid = 1'b1; s_data = d; s_last = last;
    step();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  logic [31:0] prog3[3];

  initial begin
    prog3[0] = 32'h0050_0093; prog3[1] = 32'h0010_0113; prog3[2] = 32'h0020_81B3;
    rst = 1'b0; start_load = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (3) step();
    rst = 1'b1;
    repeat (10) step();
    chk("idle cpu_rst_n", 32'(cpu_rst_n_w[0]), 32'd0);
    chk("idle s_ready", 32'(s_ready_w[0]), 32'd0);
    chk("idle imem_we", 32'(imem_we_w[0]), 32'd0);
    chk("idle boot_pc", pc_w0, 32'h0);

    // Three-word program, back to back.
    pulse_start();
    clear_logs();
    chk("load s_ready", 32'(s_ready_w[0]), 32'd1);
    for (int k = 0; k < 3; k++) send(prog3[k], k == 2);
`ifndef BOOT_CHECKSUM_EN
    chk("A release cpu_rst_n", 32'(cpu_rst_n_w[0]), 32'd0);
    chk("A last we", 32'(imem_we_w[0]), 32'd1);
    chk("A last addr", addr_w0, 32'h8);
    step();
    chk("A run cpu_rst_n", 32'(cpu_rst_n_w[0]), 32'd1);
    chk("A run busy", 32'(busy_w[0]), 32'd0);
    chk("A model run", 32'(m_run[0]), 32'd1);
    step();
    chk("A nwrites", 32'(wa0.size()), 32'd3);
    for (int k = 0; k < wa0.size() && k < 3; k++) begin
      chk($sformatf("A addr%0d", k), wa0[k], 32'(4 * k));
      chk($sformatf("A data%0d", k), wd0[k], prog3[k]);
    end
    if (wc0.size() == 3) chk("A spacing", 32'(wc0[2] - wc0[0]), 32'd2);
    if (wa1.size() >= 1) chk("A dut4 addr0", wa1[0], 32'h100);
`else
    repeat (3) step();
`endif

    // Reload from RUN/ERR with 2-cycle gaps between words.
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    chk("B reload cpu_rst_n", 32'(cpu_rst_n_w[0]), 32'd0);
    clear_logs();
    for (int k = 0; k < 3; k++) begin
      repeat (2) begin
        chk("B gap s_ready", 32'(s_ready_w[0]), 32'd1);
        step();
      end
      send(prog3[k], k == 2);
    end
    repeat (3) step();
`ifndef BOOT_CHECKSUM_EN
    chk("B nwrites", 32'(wa0.size()), 32'd3);
    for (int k = 0; k < wa0.size() && k < 3; k++) begin
      chk($sformatf("B addr%0d", k), wa0[k], 32'(4 * k));
      chk($sformatf("B data%0d", k), wd0[k], prog3[k]);
    end
    chk("B cpu_rst_n", 32'(cpu_rst_n_w[0]), 32'd1);
`endif

    // Overflow on the DEPTH=4 instance.
    pulse_start();
    clear_logs();
    for (int k = 0; k < 4; k++) send(32'hA0 + 32'(k), 1'b0);
    chk("C err", 32'(err_w[1]), 32'd1);
    chk("C cpu_rst_n", 32'(cpu_rst_n_w[1]), 32'd0);
    chk("C last we", 32'(imem_we_w[1]), 32'd1);
    chk("C model err", 32'(m_err[1]), 32'd1);
    step();
    chk("C nwrites", 32'(wa1.size()), 32'd4);
    for (int k = 0; k < wa1.size() && k < 4; k++) begin
      chk($sformatf("C addr%0d", k), wa1[k], 32'h100 + 32'(4 * k));
      chk($sformatf("C data%0d", k), wd1[k], 32'hA0 + 32'(k));
    end
    chk("C big still loading", 32'(s_ready_w[0]), 32'd1);
    pulse_start();
    chk("C restart err", 32'(err_w[1]), 32'd0);
    chk("C restart s_ready", 32'(s_ready_w[1]), 32'd1);

    // Reset in the middle of a load, with a word presented at the reset edge.
    rst = 1'b0; s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    step();
    rst = 1'b1; s_valid = 1'b0;
    chk("D we", 32'(imem_we_w[0]), 32'd0);
    chk("D s_ready", 32'(s_ready_w[0]), 32'd0);
    chk("D cpu_rst_n", 32'(cpu_rst_n_w[0]), 32'd0);
    chk("D addr", addr_w0, B0);
    clear_logs();
    repeat (5) step();
    chk("D no writes", 32'(wa0.size() + wa1.size()), 32'd0);

`ifdef BOOT_CHECKSUM_EN
    // Checksum match and mismatch.
    pulse_start();
    clear_logs();
    send(32'd1, 1'b0); send(32'd2, 1'b0); send(32'd3, 1'b1);
    chk("E check busy", 32'(busy_w[0]), 32'd1);
    chk("E check cpu_rst_n", 32'(cpu_rst_n_w[0]), 32'd0);
    step(); step();
    chk("E run", 32'(cpu_rst_n_w[0]), 32'd1);
    chk("E nwrites", 32'(wa0.size()), 32'd2);
    for (int k = 0; k < wd0.size() && k < 2; k++) chk($sformatf("E data%0d", k), wd0[k], 32'(k + 1));
    pulse_start();
    clear_logs();
    send(32'd1, 1'b0); send(32'd2, 1'b0); send(32'd4, 1'b1);
    step();
    chk("E bad err", 32'(err_w[0]), 32'd1);
    step();
    chk("E bad nwrites", 32'(wa0.size()), 32'd2);
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      start_load = ($urandom % 16) == 0;
      s_valid    = ($urandom % 3) != 0;
      s_data     = $urandom;
      s_last     = ($urandom % 24) == 0;
`ifdef BOOT_CHECKSUM_EN
      if (s_last && ($urandom % 2) == 0) s_data = m_sum[0];
`endif
      rst = ($urandom % 400) != 0;
      step();
    end
    rst = 1'b1; start_load = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    repeat (4) step();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/boot_loader_ctrl.md
BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 Parameter: BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word written and value driven on boot_pc.
REQ-002 Parameter: DEPTH, default 256, instruction-memory capacity in 32-bit words (power of two, 2..65536).
REQ-003 clk  input  1  core clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 start_load  input  1  single-cycle request to (re)load a program.
REQ-006 s_valid  input  1  loader stream word valid.
REQ-007 s_data  input  32  loader stream instruction word.
REQ-008 s_last  input  1  marks the final program word (final checksum word when BOOT_CHECKSUM_EN is defined).
REQ-009 s_ready  output  1  controller accepts a stream word.
REQ-010 imem_we  output  1  instruction-memory write enable.
REQ-011 imem_addr  output  32  instruction-memory byte address.
REQ-012 imem_wdata  output  32  instruction-memory write data.
REQ-013 cpu_rst_n  output  1  datapath reset, active-low.
REQ-014 boot_pc  output  32  datapath PC reset value; constant BASE_ADDR.
REQ-015 busy  output  1  high in LOAD, CHECK or RELEASE.
REQ-016 err  output  1  high in ERR.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, CHECK, RELEASE, RUN and ERR.
REQ-018 Handshake: a word is accepted in any cycle with s_valid=1 and s_ready=1; s_ready SHALL be 1 only in LOAD and combinational from state alone.
REQ-019 Each accepted program word SHALL appear on imem_we=1, imem_addr=BASE_ADDR+4*count, imem_wdata=s_data in the cycle after acceptance (registered, latency 1); count SHALL then increment by 1.
REQ-020 imem_we SHALL be 0 in every cycle not following an accepted program word.
REQ-021 IDLE: start_load=1 -> LOAD, with count cleared to 0.
REQ-022 LOAD: an accepted word with s_last=1 -> RELEASE, or -> CHECK when BOOT_CHECKSUM_EN is defined.
REQ-023 LOAD: an accepted program word with s_last=0 when count=DEPTH-1 (memory full, no last marker) -> ERR; that word SHALL still be written.
REQ-024 LOAD: start_load SHALL be ignored.
REQ-025 RELEASE SHALL last exactly one cycle (it lets the final write land), then go to RUN.
REQ-026 cpu_rst_n SHALL be 1 only in RUN, so it rises on the first RUN cycle, two cycles after the last word is accepted.
REQ-027 RUN: start_load=1 -> LOAD with count cleared, and cpu_rst_n SHALL be 0 in the next cycle.
REQ-028 ERR: cpu_rst_n=0 and err=1; start_load=1 -> LOAD with count cleared and err cleared.
REQ-029 A zero-length program is impossible: the first accepted word with s_last=1 is a one-word program (or, with checksum, the checksum of an empty program).
REQ-030 count SHALL be log2(DEPTH)+1 bits wide and SHALL never wrap.

Reset
REQ-031 With rst=0 at a clock edge, the controller SHALL go to IDLE with count=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, s_ready=0, cpu_rst_n=0, busy=0 and err=0.
REQ-032 Reset mid-LOAD SHALL abort the load with no further imem writes; the datapath stays held in reset.
REQ-033 boot_pc SHALL equal BASE_ADDR at all times, including during reset.

Configuration
REQ-034 Macro BOOT_CHECKSUM_EN: when defined, the s_last word is a checksum and SHALL NOT be written to memory.
REQ-035 With BOOT_CHECKSUM_EN defined, the checksum is the modulo-2^32 sum of all program words; CHECK (1 cycle) compares it with the running sum: match -> RELEASE, mismatch -> ERR.
REQ-036 Without BOOT_CHECKSUM_EN, the CHECK state and the running-sum register SHALL be absent, and the s_last word is a program word.

Verification
REQ-037 Reset then idle 10 cycles -> cpu_rst_n=0, s_ready=0, imem_we=0, boot_pc=BASE_ADDR.
REQ-038 start_load, then 3 words 0x00500093, 0x00100113, 0x002081B3 (last on the third), no checksum -> writes to 0x0, 0x4, 0x8, one per cycle; cpu_rst_n=1 two cycles after the third word is accepted.
REQ-039 Same stream with s_valid gaps of 2 cycles -> identical write sequence; s_ready stays 1 throughout LOAD.
REQ-040 DEPTH=4: 4 words with no s_last -> 4 writes, then err=1 and cpu_rst_n=0; start_load -> err=0, LOAD.
REQ-041 BOOT_CHECKSUM_EN defined: words 1, 2, checksum 3 -> 2 writes, then RUN; checksum 4 -> ERR with only 2 writes.
REQ-042 In RUN, pulse start_load -> cpu_rst_n=0 next cycle; rst=0 mid-LOAD -> IDLE, no imem_we after the reset edge.
